lstm_state_feedback: RTL

LSTM_STATE_FEEDBACK -- requirements
Module: lstm_state_feedback

---
 rtl/lstm_state_feedback.sv | 119 +++++++++++
 1 files changed

// File: rtl/lstm_state_feedback.sv
// Recurrent-state sequencer for an LSTM layer: gathers x_t, issues {h,x} to the
// front-end multiply stage and captures h_t/c_t returned by the back-stage nodes.
module lstm_state_feedback #(
  parameter  int H_NUM = 4,
  parameter  int X_NUM = 4,
  parameter  int DW    = 16,
  parameter  int T_MAX = 8,
  localparam int TW    = $clog2(T_MAX + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [TW-1:0]              seq_len,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic [X_NUM*DW-1:0]        x_in,
  output logic                       hx_valid,
  input  logic                       hx_ready,
  output logic [(H_NUM+X_NUM)*DW-1:0] hx_vec,
  input  logic                       back_valid,
  input  logic [H_NUM*DW-1:0]        h_in,
  input  logic [H_NUM*DW-1:0]        c_in,
  output logic [H_NUM*DW-1:0]        c_recu,
  output logic [TW-1:0]              t_idx,
  output logic                       busy,
  output logic                       done,
  output logic [H_NUM*DW-1:0]        h_final,
  output logic                       err
);

  typedef enum logic [2:0] {IDLE, WAIT_X, ISSUE, WAIT_H, DONE} state_t;

  state_t                r_state, w_next;
  logic [H_NUM*DW-1:0]   r_h, r_c, r_hfinal;
  logic [X_NUM*DW-1:0]   r_x;
  logic [TW-1:0]         r_t, r_len, w_len;
  logic                  r_err;
  logic                  w_last;

  // Length 0 runs one step; oversize requests saturate at T_MAX.
  always_comb begin
    w_len = seq_len;
    if (seq_len == '0)
      w_len = TW'(1);
    else if (seq_len > TW'(T_MAX))
      w_len = TW'(T_MAX);
  end

  assign w_last = (r_t == r_len - TW'(1));

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    x_ready  = 1'b0;
    hx_valid = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE:   if (start) w_next = WAIT_X;
      WAIT_X: begin
        x_ready = 1'b1;
        if (x_valid) w_next = ISSUE;
      end
      ISSUE: begin
        hx_valid = 1'b1;
        if (hx_ready) w_next = WAIT_H;
      end
      WAIT_H: if (back_valid) w_next = w_last ? DONE : WAIT_X;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_h      <= '0;
      r_c      <= '0;
      r_x      <= '0;
      r_hfinal <= '0;
      r_t      <= '0;
      r_len    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_h   <= '0;
          r_c   <= '0;
          r_t   <= '0;
          r_len <= w_len;
          r_err <= 1'b0;
        end
        WAIT_X: if (x_valid) r_x <= x_in;
        WAIT_H: if (back_valid) begin
          r_h <= h_in;
          r_c <= c_in;
          if (!w_last) r_t <= r_t + TW'(1);
        end
        DONE:    r_hfinal <= r_h;
        default: ;
      endcase
      // Stray node output outside WAIT_H wins over the clear from a same-cycle start.
      if (back_valid && r_state != WAIT_H) r_err <= 1'b1;
    end
  end

  assign hx_vec  = {r_h, r_x};
  assign c_recu  = r_c;
  assign t_idx   = r_t;
  assign busy    = (r_state != IDLE);
  assign h_final = r_hfinal;
  assign err     = r_err;

endmodule
